// File: rtl/seq_muldiv_if.sv
// Request/response bundle between the execute stage and seq_muldiv.
//
// Handshake: the requester raises op_begin for one cycle with op/a/b valid;
// the responder samples it only when idle. Completion is a level: ready stays
// high (with result and div_zero stable) until the requester pulses rst.
// There is no back-pressure; busy is informational.
interface seq_muldiv_if #(
    parameter int WIDTH = 64
);
    logic             op_begin;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             ready;
    logic [WIDTH-1:0] result;
    logic             div_zero;

    modport master (
        output op_begin, op, a, b,
        input  busy, ready, result, div_zero
    );

    modport slave (
        input  op_begin, op, a, b,
        output busy, ready, result, div_zero
    );
endinterface

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiply / restoring divide over WIDTH cycles.
// One 2*WIDTH register holds {acc, multiplier} for MUL/MULHU or
// {remainder, quotient} for DIVU/REMU; one operand register holds the
// multiplicand or the divisor. Result is held in DONE until rst.
module seq_muldiv #(
    parameter int WIDTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    seq_muldiv_if.slave       bus,
    output logic [1:0]        dbg_state_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               dz_q, dz_d;

    // Single-iteration datapath signals
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH:0]     div_rem;
    logic [2*WIDTH-1:0] step_next;
    logic               last_iter;
    logic               start_dz;

    // One shift-add or restoring-divide step applied to the current register
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + (prod_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        // Remainder is kept one bit wider during the compare so a divisor
        // with its MSB set still divides correctly.
        div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_rem   = div_ge ? (div_shift - {1'b0, opnd_q}) : div_shift;
        if (op_q[1]) begin
            step_next = {div_rem[WIDTH-1:0], prod_q[WIDTH-2:0], div_ge};
        end else begin
            step_next = {mul_sum, prod_q[WIDTH-1:1]};
        end
        last_iter = (cnt_q == CW'(WIDTH - 1));
        start_dz  = bus.op[1] && (bus.b == '0);
    end

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= 2'b00;
            cnt_q    <= '0;
            prod_q   <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            dz_q     <= dz_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.op_begin) state_d = start_dz ? S_DONE : S_RUN;
            S_RUN:  if (last_iter)    state_d = S_DONE;
            S_DONE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: latch on start, iterate in RUN, hold otherwise
    always_comb begin
        op_d     = op_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        dz_d     = dz_q;
        case (state_q)
            S_IDLE: begin
                if (bus.op_begin) begin
                    op_d  = bus.op;
                    cnt_d = '0;
                    if (start_dz) begin
                        prod_d   = '0;
                        opnd_d   = bus.b;
                        result_d = bus.op[0] ? bus.a : {WIDTH{1'b1}};
                        dz_d     = 1'b1;
                    end else begin
                        // Multiply walks the multiplier (b) through the low
                        // half; divide shifts the dividend (a) out of it.
                        prod_d = {{WIDTH{1'b0}}, (bus.op[1] ? bus.a : bus.b)};
                        opnd_d = bus.op[1] ? bus.b : bus.a;
                        dz_d   = 1'b0;
                    end
                end
            end
            S_RUN: begin
                prod_d = step_next;
                cnt_d  = cnt_q + 1'b1;
                if (last_iter) begin
                    // op[0] picks the high half (MULHU / REMU)
                    result_d = op_q[0] ? step_next[2*WIDTH-1:WIDTH]
                                       : step_next[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from state and held registers
    always_comb begin
        bus.busy     = (state_q == S_RUN);
        bus.ready    = (state_q == S_DONE);
        bus.result   = result_q;
        bus.div_zero = dz_q;
        dbg_state_o  = state_q;
    end

endmodule

// File: tb/tb_seq_muldiv.sv
module tb_seq_muldiv;
  localparam int W = 64;
  localparam int TIMEOUT = 200;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;

  seq_muldiv_if #(.WIDTH(W)) bus ();

  seq_muldiv #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic         exp_dz_q[$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Drive one request through edge E0; returns just after E0.
  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    logic [W-1:0]   e;
    logic           dz;
    p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    dz = 1'b0;
    case (op)
      2'b00: e = p[W-1:0];
      2'b01: e = p[2*W-1:W];
      2'b10: begin
        if (b == '0) begin e = {W{1'b1}}; dz = 1'b1; end
        else e = a / b;
      end
      default: begin
        if (b == '0) begin e = a; dz = 1'b1; end
        else e = a % b;
      end
    endcase
    exp_q.push_back(e);
    exp_dz_q.push_back(dz);
    @(negedge clk);
    bus.op_begin = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    bus.op_begin = 1'b0;
  endtask

  // Wait for ready (bounded), optionally inject a stray request at cycle glitch_at.
  task automatic wait_done(input string tag, input int exp_lat, input int glitch_at);
    int n;
    int busy_cnt;
    logic [W-1:0] e;
    logic         edz;
    n = 0;
    busy_cnt = 0;
    while (bus.ready !== 1'b1 && n < TIMEOUT) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (n == glitch_at) begin
        @(negedge clk);
        bus.op_begin = 1'b1;
        bus.op = 2'b00;
        bus.a = 64'd2;
        bus.b = 64'd2;
      end
      @(posedge clk);
      #1;
      bus.op_begin = 1'b0;
      n++;
    end
    chk({tag, "_latency"}, W'(n), W'(exp_lat));
    chk({tag, "_busy_cycles"}, W'(busy_cnt), W'(exp_lat));
    chk({tag, "_busy_at_done"}, W'(bus.busy), '0);
    e   = exp_q.pop_front();
    edz = exp_dz_q.pop_front();
    chk({tag, "_result"}, bus.result, e);
    chk({tag, "_div_zero"}, W'(bus.div_zero), W'(edz));
  endtask

  initial begin
    rst = 1'b1;
    bus.op_begin = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    chk("rst_busy", W'(bus.busy), '0);
    chk("rst_ready", W'(bus.ready), '0);
    chk("rst_result", bus.result, '0);
    chk("rst_div_zero", W'(bus.div_zero), '0);
    chk("rst_state", W'(dbg_state), '0);

    // MUL 7*6, then hold for 10 cycles
    start_op(2'b00, 64'd7, 64'd6);
    wait_done("mul_7x6", 64, -1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("mul_hold_ready", W'(bus.ready), W'(1));
      chk("mul_hold_result", bus.result, 64'd42);
    end
    do_reset();
    chk("post_rst_ready", W'(bus.ready), '0);
    chk("post_rst_result", bus.result, '0);

    // MULHU / MUL with all-ones * 2
    start_op(2'b01, {W{1'b1}}, 64'd2);
    wait_done("mulhu_max", 64, -1);
    do_reset();
    start_op(2'b00, {W{1'b1}}, 64'd2);
    wait_done("mul_max", 64, -1);
    do_reset();

    // divide / remainder
    start_op(2'b10, 64'd100, 64'd7);
    wait_done("divu_100_7", 64, -1);
    do_reset();
    start_op(2'b11, 64'd100, 64'd7);
    wait_done("remu_100_7", 64, -1);
    do_reset();
    start_op(2'b10, 64'd5, 64'd9);
    wait_done("divu_5_9", 64, -1);
    do_reset();
    start_op(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001);
    wait_done("remu_big_divisor", 64, -1);
    do_reset();

    // divide by zero: immediate DONE
    start_op(2'b10, 64'd123, 64'd0);
    wait_done("divu_by_zero", 0, -1);
    do_reset();
    start_op(2'b11, 64'd123, 64'd0);
    wait_done("remu_by_zero", 0, -1);
    do_reset();

    // MUL with b=0 runs full length, no div_zero
    start_op(2'b00, 64'd99, 64'd0);
    wait_done("mul_by_zero", 64, -1);
    do_reset();

    // abort MUL 3*5 mid-operation
    start_op(2'b00, 64'd3, 64'd5);
    repeat (9) @(posedge clk);
    #1;
    chk("abort_busy_before", W'(bus.busy), W'(1));
    do_reset();
    void'(exp_q.pop_front());
    void'(exp_dz_q.pop_front());
    chk("abort_busy", W'(bus.busy), '0);
    chk("abort_ready", W'(bus.ready), '0);
    start_op(2'b10, 64'd9, 64'd3);
    wait_done("divu_9_3_after_abort", 64, -1);
    do_reset();

    // stray request during RUN is ignored
    start_op(2'b10, 64'd50, 64'd5);
    wait_done("divu_50_5_glitch", 64, 19);
    // stray request during DONE is ignored
    @(negedge clk);
    bus.op_begin = 1'b1;
    bus.op = 2'b00;
    bus.a = 64'd2;
    bus.b = 64'd2;
    @(posedge clk);
    #1;
    bus.op_begin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("done_ignore_ready", W'(bus.ready), W'(1));
    chk("done_ignore_busy", W'(bus.busy), '0);
    chk("done_ignore_result", bus.result, 64'd10);
    chk("done_ignore_state", W'(dbg_state), W'(2));
    do_reset();

    // random operations
    for (int i = 0; i < 6; i++) begin
      logic [1:0]   rop;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      rop = 2'($urandom_range(0, 3));
      ra  = {32'($urandom), 32'($urandom)};
      rb  = (i < 3) ? W'($urandom_range(1, 65535)) : {32'($urandom), 32'($urandom)};
      if (rb == '0) rb = 64'd1;
      start_op(rop, ra, rb);
      wait_done("random_op", 64, -1);
      do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
